// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit (and later receive) path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int DATA_BITS = 8;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two so the
// pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == CW'(0));
  assign count_o   = count_q;
  assign data_o    = mem_q[rd_ptr_q];
  // Requests against a full/empty FIFO are ignored rather than corrupting state.
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a start/data/stop
// serialiser. tx and busy are registered from the current state.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
  localparam int BW           = $clog2(CLKS_PER_BIT);

  state_e         state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic           pop_s;
  logic           bit_end_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic [7:0]     fifo_head_s;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (wr_en),
    .pop_i   (pop_s),
    .data_i  (wr_data),
    .data_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count)
  );

  assign wr_ready  = !fifo_full_s;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign bit_end_s = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_s   = 1'b0;
    tx_d    = 1'b1;
    busy_d  = (state_q != IDLE) || !fifo_empty_s;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        bit_d  = 3'd0;
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_d = fifo_head_s;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end_s) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_end_s) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'(DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        // Chain straight into the next start bit so queued frames are contiguous.
        if (bit_end_s) begin
          baud_d = '0;
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            shift_d = fifo_head_s;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4 and a 4-entry FIFO.
module tb_uart_tx;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int total;
  int bad;
  bit mon_en;

  logic [7:0] rx_q [$];
  longint     rx_t [$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // bit i = i-th bit on the wire (start, d0..d7, stop)
  } vec_t;

  vec_t vecs [5];

  uart_tx #(
    .CLK_FREQ   (12000000),
    .BAUD       (3000000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Line receiver model: samples the first cycle of each bit after a start edge.
  initial begin
    logic [7:0] sh;
    bit         ok;
    longint     t0;
    forever begin
      @(posedge clk); #1;
      if (mon_en && rst_n && tx === 1'b0) begin
        t0 = $time;
        ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
          repeat (4) @(posedge clk); #1;
          sh[b] = tx;
          if (!rst_n) ok = 1'b0;
        end
        repeat (4) @(posedge clk); #1;
        if (!rst_n || tx !== 1'b1) ok = 1'b0;
        if (ok) begin
          rx_q.push_back(sh);
          rx_t.push_back(t0);
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge clk); #1;
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic chk_rx(input string name, input logic [7:0] exp [$]);
    chk({name, "_count"}, 32'(rx_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      chk({name, "_byte"}, 32'(rx_q[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    logic [2:0] max_cnt;
    logic [2:0] exp_cnt [6];
    logic       exp_rdy [6];
    int         tx_errs;

    total   = 0;
    bad     = 0;
    mon_en  = 1'b0;
    rst_n   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;

    vecs[0] = '{data: 8'hA5, line: 10'b1101001010};
    vecs[1] = '{data: 8'h00, line: 10'b1000000000};
    vecs[2] = '{data: 8'hFF, line: 10'b1111111110};
    vecs[3] = '{data: 8'h3C, line: 10'b1001111000};
    vecs[4] = '{data: 8'h81, line: 10'b1100000010};

    // Reset asserted between edges must take effect before any clock edge.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_tx",       32'(tx),         32'd1);
    chk("rst_wr_ready", 32'(wr_ready),   32'd1);
    chk("rst_busy",     32'(busy),       32'd0);
    chk("rst_count",    32'(fifo_count), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Single frames: exact edge-by-edge line shape plus busy fall timing.
    for (int v = 0; v < 5; v++) begin
      rx_q.delete();
      rx_t.delete();
      push_byte(vecs[v].data);                 // accepted at edge k
      @(posedge clk); #1;                      // k+1
      chk("pre_start_tx", 32'(tx),   32'd1);
      chk("busy_rise",    32'(busy), 32'd1);
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < 4; c++) begin
          @(posedge clk); #1;                  // k+2+4b+c
          chk("frame_tx", 32'(tx), 32'(vecs[v].line[b]));
        end
      end
      chk("busy_k41", 32'(busy), 32'd1);
      @(posedge clk); #1;                      // k+42
      chk("busy_k42", 32'(busy), 32'd0);
      chk_rx("single", '{vecs[v].data});
    end

    // Back-to-back writes on consecutive edges.
    rx_q.delete();
    rx_t.delete();
    wr_en   = 1'b1;
    wr_data = 8'h00;
    @(posedge clk); #1;
    chk("b2b_cnt_k", 32'(fifo_count), 32'd1);
    wr_data = 8'hFF;
    @(posedge clk); #1;
    wr_en   = 1'b0;
    chk("b2b_cnt_k1", 32'(fifo_count), 32'd1);
    max_cnt = fifo_count;
    for (int i = 0; i < 84; i++) begin
      @(posedge clk); #1;
      if (fifo_count > max_cnt) max_cnt = fifo_count;
    end
    chk("b2b_peak", 32'(max_cnt), 32'd1);
    wait_idle(200);
    chk_rx("b2b", '{8'h00, 8'hFF});
    if (rx_t.size() == 2) begin
      chk("b2b_gap", 32'(rx_t[1] - rx_t[0]), 32'd400);
    end else begin
      chk("b2b_frames", 32'(rx_t.size()), 32'd2);
    end

    // Overfill: sixth byte must be dropped once the FIFO is full.
    rx_q.delete();
    rx_t.delete();
    exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'(i + 1);
      @(posedge clk); #1;
      chk("full_count", 32'(fifo_count), 32'(exp_cnt[i]));
      chk("full_ready", 32'(wr_ready),   32'(exp_rdy[i]));
    end
    wr_en = 1'b0;
    wait_idle(400);
    chk_rx("full", '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05});

    // Push coinciding with the pop on the stop bit's last cycle.
    rx_q.delete();
    rx_t.delete();
    wr_en   = 1'b1;
    wr_data = 8'h11;
    @(posedge clk); #1;                        // k
    wr_data = 8'h22;
    @(posedge clk); #1;                        // k+1
    wr_en   = 1'b0;
    repeat (39) @(posedge clk);
    #1;                                        // k+40
    chk("pp_cnt_before", 32'(fifo_count), 32'd1);
    wr_en   = 1'b1;
    wr_data = 8'h3C;
    @(posedge clk); #1;                        // k+41
    wr_en   = 1'b0;
    chk("pp_cnt_after", 32'(fifo_count), 32'd1);
    wait_idle(400);
    chk_rx("pushpop", '{8'h11, 8'h22, 8'h3C});

    // Reset during data bit 3 with two bytes still queued.
    rx_q.delete();
    rx_t.delete();
    wr_en   = 1'b1;
    wr_data = 8'h5A;
    @(posedge clk); #1;                        // k
    wr_data = 8'h77;
    @(posedge clk); #1;                        // k+1
    wr_data = 8'h88;
    @(posedge clk); #1;                        // k+2
    wr_en   = 1'b0;
    repeat (15) @(posedge clk);
    #1;                                        // k+17: bit 2 of 5A
    chk("mid_bit2", 32'(tx), 32'd0);
    @(posedge clk); #1;                        // k+18: bit 3
    chk("mid_bit3",  32'(tx),         32'd1);
    chk("mid_count", 32'(fifo_count), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_tx",    32'(tx),         32'd1);
    chk("abort_count", 32'(fifo_count), 32'd0);
    chk("abort_busy",  32'(busy),       32'd0);
    chk("abort_ready", 32'(wr_ready),   32'd1);
    repeat (10) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tx_errs = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || busy !== 1'b0) tx_errs++;
    end
    chk("post_reset_idle", 32'(tx_errs), 32'd0);
    chk("post_reset_rx",   32'(rx_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
